// File: rtl/fa_stim_seq_if.sv
// ---------------------------------------------------------------------------
// fa_stim_seq_if
// Bundles the control inputs and stimulus outputs of the full-adder stimulus
// sequencer.
//   start, pause, abort : run control (driven by the master)
//   a, b, cin           : full-adder operand / carry-in stimulus
//   vec_valid           : strobe on the first cycle of each new vector
//   vec_idx             : index of the vector currently driven
//   busy, done          : run in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
interface fa_stim_seq_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic       a;
    logic       b;
    logic       cin;
    logic       vec_valid;
    logic [3:0] vec_idx;
    logic       busy;
    logic       done;

    modport master (
        output start, pause, abort,
        input  a, b, cin, vec_valid, vec_idx, busy, done
    );

    modport slave (
        input  start, pause, abort,
        output a, b, cin, vec_valid, vec_idx, busy, done
    );
endinterface

// File: rtl/fa_stim_seq.sv
// ---------------------------------------------------------------------------
// fa_stim_seq
// Steps a full adder through NUM_VEC stimulus vectors, holding each one for
// HOLD_CYC un-paused clock cycles. The stimulus {a,b,cin} is the low three
// bits of the vector index, so indices 8..15 repeat the 000..111 pattern.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fa_stim_seq_if.slave (start/pause/abort in; stimulus, vec_valid,
//           vec_idx, busy, done out -- all outputs come straight from flops)
// abort acts as a synchronous clear with priority over start and pause.
// ---------------------------------------------------------------------------
module fa_stim_seq #(
    parameter int NUM_VEC  = 15,
    parameter int HOLD_CYC = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fa_stim_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [3:0] IDX_LAST  = 4'(NUM_VEC - 1);

    state_t     state_r, state_s;
    logic [7:0] hcnt_r,  hcnt_s;
    logic [3:0] idx_r,   idx_s;
    logic       vv_r,    vv_s;
    logic       busy_r,  busy_s;
    logic       done_r,  done_s;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            hcnt_r  <= 8'd0;
            idx_r   <= 4'd0;
            vv_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            hcnt_r  <= hcnt_s;
            idx_r   <= idx_s;
            vv_r    <= vv_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        hcnt_s  = hcnt_r;
        idx_s   = idx_r;
        vv_s    = 1'b0;
        done_s  = 1'b0;

        if (bus.abort) begin
            state_s = IDLE;
            hcnt_s  = 8'd0;
            idx_s   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_s = RUN;
                        hcnt_s  = 8'd0;
                        idx_s   = 4'd0;
                        vv_s    = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        // Frozen: counters hold, strobe suppressed
                        state_s = RUN;
                    end else if (hcnt_r != HOLD_LAST) begin
                        hcnt_s = hcnt_r + 8'd1;
                    end else if (idx_r != IDX_LAST) begin
                        idx_s  = idx_r + 4'd1;
                        hcnt_s = 8'd0;
                        vv_s   = 1'b1;
                    end else begin
                        // Last vector served its full hold time
                        state_s = DONE;
                        done_s  = 1'b1;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    hcnt_s  = 8'd0;
                    idx_s   = 4'd0;
                end
            endcase
        end

        busy_s = (state_s == RUN);
    end

    // Stimulus is the truncated vector index; both come from the same flops
    assign bus.a         = idx_r[2];
    assign bus.b         = idx_r[1];
    assign bus.cin       = idx_r[0];
    assign bus.vec_idx   = idx_r;
    assign bus.vec_valid = vv_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_fa_stim_seq.sv
module tb_fa_stim_seq;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fa_stim_seq_if if0 ();
    fa_stim_seq_if if1 ();

    fa_stim_seq u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    fa_stim_seq #(.NUM_VEC(4), .HOLD_CYC(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    localparam int NV0 = 15;
    localparam int HC0 = 5;

    int n_err = 0;
    int n_chk = 0;

    // Reference model for u_dut0: progress measured as non-paused RUN cycles
    int m_mode;   // 0 idle, 1 run, 2 done
    int m_t;
    int m_idx;
    bit m_vv;
    bit m_done;

    function automatic void m_reset();
        m_mode = 0; m_t = 0; m_idx = 0; m_vv = 1'b0; m_done = 1'b0;
    endfunction

    function automatic void m_step(bit st, bit pa, bit ab);
        m_done = 1'b0;
        if (ab) begin
            m_reset();
        end else if (m_mode == 0) begin
            m_vv = 1'b0;
            if (st) begin
                m_mode = 1; m_t = 0; m_idx = 0; m_vv = 1'b1;
            end
        end else if (m_mode == 1) begin
            if (pa) begin
                m_vv = 1'b0;
            end else begin
                m_t = m_t + 1;
                if (m_t == NV0 * HC0) begin
                    m_mode = 2; m_done = 1'b1; m_vv = 1'b0;
                end else begin
                    m_idx = m_t / HC0;
                    m_vv  = ((m_t % HC0) == 0);
                end
            end
        end else begin
            m_mode = 0; m_vv = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check0(input string name);
        logic [9:0] got, exp;
        got = {if0.vec_valid, if0.vec_idx, if0.a, if0.b, if0.cin, if0.busy, if0.done};
        exp = {m_vv, 4'(m_idx), 3'(m_idx), (m_mode == 1), m_done};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step(if0.start, if0.pause, if0.abort);
        #1;
        check0("model");
    endtask

    // One full run on u_dut0; pause held for the edges closing cycles
    // pause_at .. pause_at+pause_len-1
    task automatic run_full(input string name, input int pause_at, input int pause_len,
                            output int done_cyc, output int strobes);
        int cyc;
        int exp_cyc;
        done_cyc = -1;
        strobes  = 0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 200; k++) begin
            if (if0.vec_valid) begin
                exp_cyc = 1 + HC0 * strobes + ((pause_len > 0 && strobes >= 3) ? pause_len : 0);
                chk({name, "_strobe_cyc"}, cyc, exp_cyc);
                chk({name, "_abc"}, int'({if0.a, if0.b, if0.cin}), strobes % 8);
                strobes++;
            end
            if (if0.done) begin
                done_cyc = cyc;
                break;
            end
            if0.pause = (cyc >= pause_at && cyc < pause_at + pause_len);
            tick();
            cyc++;
        end
        if0.pause = 1'b0;
        tick();
    endtask

    typedef struct {
        logic       st, pa, ab;
        logic       vv;
        logic [3:0] idx;
        logic [2:0] abc;
        logic       busy, done;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic st, logic pa, logic ab, logic vv, logic [3:0] idx,
                                logic [2:0] abc, logic busy, logic done);
        vec_t v;
        v.st = st; v.pa = pa; v.ab = ab; v.vv = vv; v.idx = idx;
        v.abc = abc; v.busy = busy; v.done = done;
        return v;
    endfunction

    initial begin
        int dc, sb, cnt, c, d1, d2;
        logic [9:0] got1, exp1;

        // NUM_VEC=4, HOLD_CYC=1 vectors: {start,pause,abort} -> outputs after edge
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 3'd1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 3'd3, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd3, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 3'd3, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 3'd1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 3'd1, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 3'd3, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 3'd3, 1'b0, 1'b1);
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 3'd3, 1'b0, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 3'd0, 1'b1, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0);

        if0.start = 1'b0; if0.pause = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.pause = 1'b0; if1.abort = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        m_reset();
        check0("reset0");
        chk("reset1", int'({if1.vec_valid, if1.vec_idx, if1.a, if1.b, if1.cin, if1.busy, if1.done}), 0);
        #9 rst_n = 1'b1;

        // Default run: 15 strobes 5 apart, done at cycle 76
        run_full("full", 0, 0, dc, sb);
        chk("full_done_cyc", dc, 76);
        chk("full_strobes", sb, NV0);

        // Pause 3 cycles inside vector 2: done slips to 79, no extra strobe
        run_full("pause", 12, 3, dc, sb);
        chk("pause_done_cyc", dc, 79);
        chk("pause_strobes", sb, NV0);

        // abort beats start in IDLE, then abort at vector 6
        if0.start = 1'b1; if0.abort = 1'b1;
        tick();
        chk("abort_start_busy", int'(if0.busy), 0);
        if0.start = 1'b0; if0.abort = 1'b0;
        tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        cnt = 0;
        while (!(if0.vec_valid && if0.vec_idx == 4'd6) && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reach_vec6", int'(cnt < 100), 1);
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        chk("abort_outputs", int'({if0.vec_valid, if0.vec_idx, if0.a, if0.b, if0.cin, if0.busy, if0.done}), 0);
        cnt = 0;
        for (int k = 0; k < 90; k++) begin
            tick();
            if (if0.done) cnt++;
        end
        chk("abort_no_done", cnt, 0);

        // Asynchronous reset mid-vector 9, then a fresh run from index 0
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        cnt = 0;
        while (!(if0.vec_valid && if0.vec_idx == 4'd9) && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("reach_vec9", int'(cnt < 100), 1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check0("async_reset");
        #1 rst_n = 1'b1;
        tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("rerun_idx", int'(if0.vec_idx), 0);
        chk("rerun_strobe", int'(if0.vec_valid), 1);
        cnt = 0;
        while (!if0.done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("rerun_done_seen", int'(if0.done), 1);
        tick();

        // start held high: back-to-back runs, done at 76 and 153
        if0.start = 1'b1;
        d1 = -1; d2 = -1; cnt = 0;
        for (c = 1; c <= 160; c++) begin
            tick();
            if (if0.done) begin
                cnt++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        if0.start = 1'b0;
        chk("b2b_done_cnt", cnt, 2);
        chk("b2b_done1", d1, 76);
        chk("b2b_done2", d2, 153);
        for (int k = 0; k < 80; k++) tick();

        // Randomized control against the model
        for (int k = 0; k < 3000; k++) begin
            if0.start = ($urandom_range(3) == 0);
            if0.pause = ($urandom_range(3) == 0);
            if0.abort = ($urandom_range(49) == 0);
            tick();
        end
        if0.start = 1'b0; if0.pause = 1'b0; if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;

        // Table-driven checks on the NUM_VEC=4, HOLD_CYC=1 instance
        for (int i = 0; i < 20; i++) begin
            if1.start = tbl[i].st;
            if1.pause = tbl[i].pa;
            if1.abort = tbl[i].ab;
            tick();
            got1 = {if1.vec_valid, if1.vec_idx, if1.a, if1.b, if1.cin, if1.busy, if1.done};
            exp1 = {tbl[i].vv, tbl[i].idx, tbl[i].abc, tbl[i].busy, tbl[i].done};
            n_chk++;
            if (got1 !== exp1) begin
                n_err++;
                $display("FAIL table row=%0d got=%b exp=%b", i, got1, exp1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fa_stim_seq.md
FA_STIM_SEQ -- requirements
Module: fa_stim_seq

Interface
REQ-001 The block SHALL have parameter NUM_VEC, default 15, number of vectors per run, legal range 1..16.
REQ-002 The block SHALL have parameter HOLD_CYC, default 5, clock cycles each vector is held, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, level request to begin a run; sampled only in IDLE.
REQ-006 The block SHALL have port pause, input, 1 bit, freezes sequencing while high in RUN.
REQ-007 The block SHALL have port abort, input, 1 bit, terminates any activity and returns to IDLE.
REQ-008 The block SHALL have ports a, b and cin, each output, 1 bit, full-adder operand and carry-in stimulus (registered).
REQ-009 The block SHALL have port vec_valid, output, 1 bit, one-cycle strobe marking the first cycle of each new vector.
REQ-010 The block SHALL have port vec_idx, output, 4 bits, index of the vector currently driven.
REQ-011 The block SHALL have port busy, output, 1 bit, high exactly while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit, one-cycle pulse on normal run completion.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL use an internal 8-bit hold counter hcnt.
REQ-014 In IDLE with start=1 and abort=0 at an edge, the FSM SHALL enter RUN with vec_idx=0, hcnt=0, {a,b,cin}=3'b000 and vec_valid=1.
REQ-015 The stimulus SHALL be {a,b,cin} = vec_idx[2:0] (truncation), so index 8 drives 000 and index 14 drives 110.
REQ-016 In RUN with pause=0 and hcnt<HOLD_CYC-1, the block SHALL increment hcnt and hold all outputs, with vec_valid=0.
REQ-017 In RUN with pause=0, hcnt=HOLD_CYC-1 and vec_idx<NUM_VEC-1, the block SHALL increment vec_idx, clear hcnt, drive the new vector and pulse vec_valid=1.
REQ-018 In RUN with pause=0, hcnt=HOLD_CYC-1 and vec_idx=NUM_VEC-1, the FSM SHALL enter DONE.
REQ-019 Each vector SHALL therefore be presented for exactly HOLD_CYC non-paused cycles; with HOLD_CYC=1, vec_valid SHALL stay high for every RUN cycle.
REQ-020 In RUN with pause=1, hcnt, vec_idx, a, b and cin SHALL hold, and vec_valid SHALL be 0 even if pause rises in a strobe cycle.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then the FSM SHALL unconditionally return to IDLE; start in DONE SHALL be ignored.
REQ-022 After completion, a, b, cin and vec_idx SHALL retain their last values in DONE and IDLE until the next start, abort or reset.
REQ-023 start while in RUN SHALL be ignored, and a new run SHALL restart from index 0.
REQ-024 abort=1 in any state SHALL, at the next edge, force IDLE with a=b=cin=0, vec_idx=0, hcnt=0, vec_valid=0, busy=0 and done=0.
REQ-025 abort SHALL take priority over start and pause when they are asserted simultaneously.
REQ-026 With defaults and start sampled at cycle 0, RUN SHALL occupy cycles 1..75 and done SHALL be high at cycle 76.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force IDLE, a=b=cin=0, vec_idx=0, hcnt=0, vec_valid=0, busy=0 and done=0.
REQ-028 Reset asserted mid-RUN SHALL discard the run, with no done pulse, and the first edge after release SHALL only sample start.

Verification
REQ-029 Defaults with a one-cycle start pulse -> 15 vec_valid strobes 5 cycles apart, {a,b,cin} sequence 000..111,000..110, done only at cycle 76.
REQ-030 HOLD_CYC=1 and NUM_VEC=4 -> vec_valid high for cycles 1..4, vec_idx 0,1,2,3, done at cycle 5.
REQ-031 pause high for 3 cycles during vector 2 -> vector 2 is held for 8 cycles, no extra strobe, done delayed to cycle 79.
REQ-032 abort together with start in IDLE, then abort at vector 6 -> FSM stays IDLE, then all outputs are 0 next cycle and done is never asserted.
REQ-033 rst_n low mid-vector 9, asynchronously between edges -> outputs go 0 before the next edge, and a fresh start rereuns from index 0.
REQ-034 start held high continuously -> back-to-back runs, each with done, and RUN re-entered two cycles after DONE via IDLE.
